// File: rtl/click_keypad.sv
// click_keypad: turns mouse clicks on an on-screen keypad grid into key codes.
//
// A COLS x ROWS grid of CELL_W x CELL_H cells sits at (X0, Y0). A press edge
// on a cell pushes that cell's code (row*COLS+col) into a first-word-fall-through
// queue. With MODE=1, holding the button on the same cell auto-repeats the code
// after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles. Sliding off
// the cell while held abandons the press until the button is released.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   mouse_x/y    cursor position (synchronous to clk)
//   btn          button level, 1 = pressed
//   code_ready   consumer accepts the head code this cycle
//   code         head-of-queue key code (0 when empty)
//   code_valid   queue not empty
//   fifo_full    queue holds FIFO_DEPTH entries
//   overflow     sticky: a code was dropped because the queue was full
//   press_active FSM is in PRESSED
module click_keypad #(
    parameter int X0            = 160,
    parameter int Y0            = 120,
    parameter int CELL_W        = 80,
    parameter int CELL_H        = 60,
    parameter int COLS          = 4,
    parameter int ROWS          = 5,
    parameter int CODE_W        = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int MODE          = 0,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        mouse_x,
    input  logic [8:0]        mouse_y,
    input  logic              btn,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              fifo_full,
    output logic              overflow,
    output logic              press_active
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [31:0] X_LO  = 32'(X0);
    localparam logic [31:0] Y_LO  = 32'(Y0);
    localparam logic [31:0] X_HI  = 32'(X0 + COLS * CELL_W);
    localparam logic [31:0] Y_HI  = 32'(Y0 + ROWS * CELL_H);
    localparam logic [31:0] DLY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PER_LAST = 32'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, IGNORE} state_t;

    // ---------------- hit test (combinational, constant divisors) -----------
    logic [31:0]       mx, my;
    logic              in_grid;
    logic [CODE_W-1:0] cell_code;

    always_comb begin
        mx        = {22'd0, mouse_x};
        my        = {23'd0, mouse_y};
        in_grid   = (mx >= X_LO) && (mx < X_HI) && (my >= Y_LO) && (my < Y_HI);
        cell_code = CODE_W'(((my - Y_LO) / 32'(CELL_H)) * 32'(COLS)
                            + (mx - X_LO) / 32'(CELL_W));
    end

    // ---------------- press FSM --------------------------------------------
    state_t            state;
    logic              btn_d;
    logic              armed;        // 0 only in the first cycle after reset
    logic [CODE_W-1:0] latched;
    logic [31:0]       rpt_cnt;
    logic              rpt_started;  // first repeat already issued
    logic              press_edge, on_cell, rpt_hit, push;
    logic [CODE_W-1:0] push_code;

    // armed masks the spurious edge seen when btn is already high at reset release
    assign press_edge = armed & btn & ~btn_d;
    assign on_cell    = in_grid && (cell_code == latched);
    assign rpt_hit    = (MODE == 1) && (state == PRESSED) && btn && on_cell &&
                        (rpt_started ? (rpt_cnt == PER_LAST) : (rpt_cnt == DLY_LAST));
    assign push       = ((state == IDLE) && press_edge && in_grid) || rpt_hit;
    assign push_code  = (state == IDLE) ? cell_code : latched;
    assign press_active = (state == PRESSED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            btn_d       <= 1'b0;
            armed       <= 1'b0;
            latched     <= '0;
            rpt_cnt     <= '0;
            rpt_started <= 1'b0;
        end else begin
            btn_d <= btn;
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (press_edge) begin
                        if (in_grid) begin
                            latched     <= cell_code;
                            rpt_cnt     <= '0;
                            rpt_started <= 1'b0;
                            state       <= PRESSED;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end
                PRESSED: begin
                    // release wins over sliding off the cell
                    if (!btn) begin
                        state <= IDLE;
                    end else if (!on_cell) begin
                        state <= IGNORE;
                    end else if (MODE == 1) begin
                        if (rpt_hit) begin
                            rpt_cnt     <= '0;
                            rpt_started <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 32'd1;
                        end
                    end
                end
                IGNORE: begin
                    if (!btn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- FWFT code queue --------------------------------------
    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              pop, wr_en;

    assign code_valid = (count != '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = code_valid & code_ready;
    // a pop in the same cycle frees the slot a full queue needs
    assign wr_en      = push & (~fifo_full | pop);
    assign code       = code_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(wr_en) - CW'(pop);
            overflow <= overflow | (push & fifo_full & ~pop);
        end
    end
endmodule

// File: tb/tb_click_keypad.sv
// Bench for click_keypad: a default-parameter instance (dut0) and an
// auto-repeat instance (dut1) share clock, reset, cursor and button.
module tb_click_keypad;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] mouse_x = '0;
    logic [8:0] mouse_y = '0;
    logic       btn = 1'b0;
    logic       ready0 = 1'b0, ready1 = 1'b0;
    logic [4:0] code0, code1;
    logic       valid0, full0, ovf0, act0;
    logic       valid1, full1, ovf1, act1;

    always #5 clk = ~clk;

    click_keypad dut0 (
        .clk(clk), .reset(reset), .mouse_x(mouse_x), .mouse_y(mouse_y), .btn(btn),
        .code_ready(ready0), .code(code0), .code_valid(valid0), .fifo_full(full0),
        .overflow(ovf0), .press_active(act0)
    );

    click_keypad #(.MODE(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .reset(reset), .mouse_x(mouse_x), .mouse_y(mouse_y), .btn(btn),
        .code_ready(ready1), .code(code1), .code_valid(valid1), .fifo_full(full1),
        .overflow(ovf1), .press_active(act1)
    );

    int total = 0;
    int bad = 0;
    logic [4:0] q0[$];

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       hit;
        logic [4:0] code;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock: a pop on dut0 is scored against the expected queue first.
    task automatic tick();
        if (valid0 && ready0) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got code %0d want no entry", code0);
            end else begin
                chk("pop_code", code0, q0.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ready0 = 1'b1;
        for (int i = 0; i < 12 && valid0; i++) tick();
        ready0 = 1'b0;
        chk("drain_empty", valid0, 0);
        chk("drain_sb_empty", q0.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        btn = 1'b0;
        ready0 = 1'b0;
        ready1 = 1'b0;
        q0.delete();
        tick();
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic place(input logic [9:0] x, input logic [8:0] y);
        mouse_x = x;
        mouse_y = y;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pushes[$];
        int exp_rep[6] = '{0, 10, 14, 18, 22, 26};
        logic [9:0] fx[5] = '{10'd170, 10'd250, 10'd330, 10'd410, 10'd170};
        logic [8:0] fy[5] = '{9'd130, 9'd130, 9'd130, 9'd130, 9'd190};
        logic [4:0] fc[5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};

        vecs[0]  = '{10'd250, 9'd200, 1'b1, 5'd5};
        vecs[1]  = '{10'd160, 9'd120, 1'b1, 5'd0};
        vecs[2]  = '{10'd479, 9'd419, 1'b1, 5'd19};
        vecs[3]  = '{10'd480, 9'd419, 1'b0, 5'd0};
        vecs[4]  = '{10'd159, 9'd200, 1'b0, 5'd0};
        vecs[5]  = '{10'd170, 9'd130, 1'b1, 5'd0};
        vecs[6]  = '{10'd250, 9'd130, 1'b1, 5'd1};
        vecs[7]  = '{10'd400, 9'd300, 1'b1, 5'd15};
        vecs[8]  = '{10'd479, 9'd120, 1'b1, 5'd3};
        vecs[9]  = '{10'd160, 9'd419, 1'b1, 5'd16};
        vecs[10] = '{10'd160, 9'd420, 1'b0, 5'd0};

        // reset state
        #1;
        chk("rst_code", code0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_full", full0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_active", act0, 0);
        chk("rst_valid1", valid1, 0);
        tick();
        reset = 1'b1;
        tick();
        tick();

        // table of single clicks
        foreach (vecs[i]) begin
            place(vecs[i].x, vecs[i].y);
            btn = 1'b1;
            if (vecs[i].hit) q0.push_back(vecs[i].code);
            tick();
            chk("vec_valid", valid0, vecs[i].hit);
            chk("vec_active", act0, vecs[i].hit);
            if (vecs[i].hit) chk("vec_code", code0, vecs[i].code);
            repeat (3) tick();
            btn = 1'b0;
            tick();
            chk("vec_release", act0, 0);
            drain();
        end
        do_reset();

        // long hold with no consumer: exactly one entry
        place(10'd250, 9'd200);
        btn = 1'b1;
        q0.push_back(5'd5);
        tick();
        chk("hold_code", code0, 5);
        repeat (99) tick();
        chk("hold_active", act0, 1);
        chk("hold_full", full0, 0);
        btn = 1'b0;
        tick();
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
        chk("hold_one_entry", valid0, 0);
        do_reset();

        // fill to full, then overflow on the fifth click
        for (int i = 0; i < 5; i++) begin
            place(fx[i], fy[i]);
            btn = 1'b1;
            if (i < 4) q0.push_back(fc[i]);
            tick();
            btn = 1'b0;
            tick();
            chk("fill_full", full0, (i >= 3));
            chk("fill_ovf", ovf0, (i >= 4));
        end
        drain();
        chk("ovf_sticky", ovf0, 1);
        do_reset();

        // full queue: pop and click on the same edge
        for (int i = 0; i < 4; i++) begin
            place(fx[i], fy[i]);
            btn = 1'b1;
            q0.push_back(fc[i]);
            tick();
            btn = 1'b0;
            tick();
        end
        place(10'd250, 9'd200);
        btn = 1'b1;
        ready0 = 1'b1;
        q0.push_back(5'd5);
        tick();
        ready0 = 1'b0;
        chk("pp_full", full0, 1);
        chk("pp_ovf", ovf0, 0);
        btn = 1'b0;
        tick();
        drain();
        do_reset();

        // slide off the cell while held
        place(10'd170, 9'd130);
        btn = 1'b1;
        q0.push_back(5'd0);
        tick();
        chk("slide_active", act0, 1);
        place(10'd250, 9'd130);
        tick();
        chk("slide_ignore", act0, 0);
        place(10'd170, 9'd130);
        repeat (3) tick();
        chk("slide_stay_ignore", act0, 0);
        btn = 1'b0;
        tick();
        drain();

        // reset mid-hold with entries queued, then release with btn high
        place(10'd250, 9'd200);
        btn = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", valid0, 0);
        chk("mid_rst_code", code0, 0);
        chk("mid_rst_active", act0, 0);
        chk("mid_rst_ovf", ovf0, 0);
        chk("mid_rst_valid1", valid1, 0);
        q0.delete();
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("post_rst_no_push", valid0, 0);
        chk("post_rst_idle", act0, 0);
        btn = 1'b0;
        tick();
        btn = 1'b1;
        q0.push_back(5'd5);
        tick();
        chk("post_rst_press", code0, 5);
        btn = 1'b0;
        tick();
        drain();
        do_reset();

        // auto-repeat timing on dut1
        ready1 = 1'b1;
        place(10'd170, 9'd130);
        btn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 30) btn = 1'b0;
            tick();
            if (valid1) begin
                pushes.push_back(k);
                chk("rep_code", code1, 0);
            end
        end
        chk("rep_count", pushes.size(), 6);
        for (int i = 0; i < 6 && i < pushes.size(); i++) chk("rep_cycle", pushes[i], exp_rep[i]);
        do_reset();

        // repeats stop after sliding off the cell
        pushes.delete();
        ready1 = 1'b1;
        place(10'd170, 9'd130);
        btn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 12) place(10'd250, 9'd130);
            tick();
            if (valid1) begin
                pushes.push_back(k);
                chk("move_code", code1, 0);
            end
        end
        chk("move_active", act1, 0);
        chk("move_count", pushes.size(), 2);
        btn = 1'b0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/click_keypad.md
CLICK_KEYPAD -- requirements
Module: click_keypad

Interface
REQ-001 The module SHALL have parameter X0, default 160, meaning grid left edge in pixels.
REQ-002 The module SHALL have parameter Y0, default 120, meaning grid top edge in pixels.
REQ-003 The module SHALL have parameters CELL_W and CELL_H, defaults 80 and 60, meaning cell width and height in pixels.
REQ-004 The module SHALL have parameters COLS and ROWS, defaults 4 and 5, meaning grid dimensions, with COLS*ROWS <= 2^CODE_W.
REQ-005 The module SHALL have parameter CODE_W, default 5, meaning key-code width.
REQ-006 The module SHALL have parameter FIFO_DEPTH, default 4, meaning code queue entries, a power of two >= 2.
REQ-007 The module SHALL have parameter MODE, default 0, meaning 0 = single code per click and 1 = auto-repeat.
REQ-008 The module SHALL have parameters REPEAT_DELAY and REPEAT_PERIOD, defaults 12500000 and 2500000, meaning clk cycles to first repeat and between repeats.
REQ-009 The module SHALL have port clk, input, 1 bit, meaning the single system clock; all logic SHALL be on its rising edge.
REQ-010 The module SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset.
REQ-011 The module SHALL have port mouse_x, input, 10 bits, meaning cursor column, already synchronous to clk.
REQ-012 The module SHALL have port mouse_y, input, 9 bits, meaning cursor row, already synchronous to clk.
REQ-013 The module SHALL have port btn, input, 1 bit, meaning button level (1 = pressed), already synchronous to clk.
REQ-014 The module SHALL have port code_ready, input, 1 bit, meaning the consumer accepts the head code.
REQ-015 The module SHALL have port code, output, CODE_W bits, meaning the head-of-queue key code.
REQ-016 The module SHALL have port code_valid, output, 1 bit, meaning the queue is not empty.
REQ-017 The module SHALL have port fifo_full, output, 1 bit, meaning the queue holds FIFO_DEPTH entries.
REQ-018 The module SHALL have port overflow, output, 1 bit, meaning sticky dropped-code flag.
REQ-019 The module SHALL have port press_active, output, 1 bit, meaning the FSM is in PRESSED.

Function
REQ-020 Hit test SHALL be: in_grid when X0 <= mouse_x < X0+COLS*CELL_W and Y0 <= mouse_y < Y0+ROWS*CELL_H; col = (mouse_x-X0)/CELL_W; row = (mouse_y-Y0)/CELL_H; cell code = row*COLS+col; the test SHALL be evaluated from current inputs, with no divider latency.
REQ-021 A registered copy btn_d SHALL be kept; a press edge is btn=1 with btn_d=0.
REQ-022 FSM states SHALL be IDLE, PRESSED and IGNORE.
REQ-023 In IDLE, a press edge with in_grid SHALL latch the cell code, push it into the queue, and go to PRESSED.
REQ-024 In IDLE, a press edge with !in_grid SHALL go to IGNORE with no push.
REQ-025 In PRESSED, btn=0 SHALL go to IDLE; when the cell code differs from the latched code or !in_grid, the FSM SHALL go to IGNORE; release takes priority over the cell change.
REQ-026 In PRESSED with MODE=1, a repeat counter SHALL start at 0 on entry and push the latched code when it reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles until PRESSED is exited; MODE=0 SHALL never repeat.
REQ-027 In IGNORE, btn=0 SHALL go to IDLE, and no pushes SHALL occur.
REQ-028 The queue SHALL be first-word-fall-through: code reflects the head whenever code_valid=1, and a pushed code SHALL appear on code with code_valid=1 in the cycle after the push edge when the queue was empty.
REQ-029 A pop SHALL occur on a clock edge with code_valid=1 and code_ready=1; code_ready with an empty queue SHALL have no effect.
REQ-030 A push to a full queue with no simultaneous pop SHALL be dropped and set overflow, which stays 1 until reset.
REQ-031 A simultaneous push and pop when full SHALL both be accepted, with no overflow.
REQ-032 A simultaneous push and pop when empty SHALL accept the push, with code_valid=1 afterwards.
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL never exceed FIFO_DEPTH.

Reset
REQ-034 While reset=0, the module SHALL be in IDLE with btn_d=0, queue empty, code=0, code_valid=0, fifo_full=0, overflow=0, press_active=0, and repeat counter=0.
REQ-035 Reset asserted mid-press or mid-repeat SHALL discard all queued codes immediately.
REQ-036 After reset release with btn already 1, no push SHALL occur until btn returns to 0 and a new press edge occurs (btn_d is loaded without an edge on the first cycle).

Verification
REQ-037 With defaults, btn 0->1 at (250,200), code_ready=0 -> code=5, code_valid=1 one cycle after the edge, press_active=1, and exactly one entry after a 100-cycle hold.
REQ-038 Presses at (479,419) and (480,419) -> code 19 queued for the first and nothing for the second, with FSM in IGNORE until release.
REQ-039 Five clicks with code_ready=0 -> fifo_full=1 after the fourth, overflow=1 after the fifth, and a drain yields the first four codes in order.
REQ-040 With MODE=1, REPEAT_DELAY=10, REPEAT_PERIOD=4 and a 30-cycle hold on cell 0 -> pushes on cycles 0, 10, 14, 18, 22, 26 after the edge, 6 codes total (FIFO_DEPTH=8).
REQ-041 Cursor moved from (170,130) to (250,130) while held -> FSM goes to IGNORE, no code 1 is pushed, and repeats stop.
REQ-042 With the queue full, code_ready=1 and a new click in the same cycle -> occupancy stays 4 and overflow=0; reset asserted mid-hold -> all outputs 0 immediately.
